// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline stage of the DIAGV core.
// Holds the bus widths and the occupancy state encoding.
// Optional feature macro EX_MEM_FORWARD_EN is left undefined by default.
package ex_mem_stage_pkg;

   localparam int unsigned DataBusBits = 32;
   localparam int unsigned RegAddrBits = 5;

   typedef enum logic [1:0] {
      ExMemEmpty = 2'd0,
      ExMemOne   = 2'd1,
      ExMemFull  = 2'd2
   } ex_mem_state_t;

   // Width of the concatenated payload: result, store data, rd, rd_we, mem_rd, mem_wr.
   function automatic int unsigned payload_bits(input int unsigned data_w, input int unsigned rd_w);
      return 2 * data_w + rd_w + 3;
   endfunction

endpackage

// File: rtl/ex_mem_stage_slot.sv
// stage_slot: payload register with load enable and asynchronous clear.
// Used twice by ex_mem_stage (main/head slot and skid slot).
module stage_slot #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Capture d when load is asserted; clear on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with a two-entry skid buffer.
// in_ready and out_* are register outputs; flush empties both slots.
// Define EX_MEM_FORWARD_EN to build the EX/MEM forwarding comparators;
// otherwise the forwarding outputs are tied to zero.
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DataBusBits,
   parameter int unsigned RD_W   = RegAddrBits
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [DATA_W-1:0] in_store_data,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_rd_we,
   input  logic              in_mem_rd,
   input  logic              in_mem_wr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [DATA_W-1:0] out_store_data,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_rd_we,
   output logic              out_mem_rd,
   output logic              out_mem_wr,
   input  logic [RD_W-1:0]   fwd_rs1,
   input  logic [RD_W-1:0]   fwd_rs2,
   output logic              fwd1_hit,
   output logic              fwd2_hit,
   output logic [DATA_W-1:0] fwd_data,
   output logic              fwd_load_hazard
);

   localparam int unsigned PW = payload_bits(DATA_W, RD_W);

   ex_mem_state_t state, state_nx;
   logic          accept, pop;
   logic          load_main, load_skid, sel_skid;
   logic          out_valid_q, in_ready_q;
   logic [PW-1:0] in_pl, main_d, main_q, skid_q;

   assign accept = in_valid & in_ready_q;
   assign pop    = out_valid_q & out_ready;
   assign in_pl  = {in_result, in_store_data, in_rd, in_rd_we, in_mem_rd, in_mem_wr};
   assign main_d = sel_skid ? skid_q : in_pl;

   // Next-state and slot-load decode; flush overrides everything and drops any accept.
   always_comb begin
      state_nx  = state;
      load_main = 1'b0;
      load_skid = 1'b0;
      sel_skid  = 1'b0;
      unique case (state)
         ExMemEmpty: begin
            if (accept) begin
               load_main = 1'b1;
               state_nx  = ExMemOne;
            end
         end
         ExMemOne: begin
            if (accept && pop) begin
               load_main = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_nx  = ExMemFull;
            end else if (pop) begin
               state_nx  = ExMemEmpty;
            end
         end
         ExMemFull: begin
            if (pop) begin
               load_main = 1'b1;
               sel_skid  = 1'b1;
               state_nx  = ExMemOne;
            end
         end
         default: state_nx = ExMemEmpty;
      endcase
      if (flush) begin
         state_nx  = ExMemEmpty;
         load_main = 1'b0;
         load_skid = 1'b0;
      end
   end

   // State register plus registered handshake outputs decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ExMemEmpty;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state       <= state_nx;
         out_valid_q <= (state_nx != ExMemEmpty);
         in_ready_q  <= (state_nx != ExMemFull);
      end
   end

   stage_slot #(.W(PW)) u_main (
      .clk  (clk),
      .rst  (rst),
      .load (load_main),
      .d    (main_d),
      .q    (main_q)
   );

   stage_slot #(.W(PW)) u_skid (
      .clk  (clk),
      .rst  (rst),
      .load (load_skid),
      .d    (in_pl),
      .q    (skid_q)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign {out_result, out_store_data, out_rd, out_rd_we, out_mem_rd, out_mem_wr} = main_q;

`ifdef EX_MEM_FORWARD_EN
   // Only the head entry forwards; the skid is occupied only while decode is stalled.
   assign fwd1_hit        = out_valid_q & out_rd_we & (out_rd == fwd_rs1) & (fwd_rs1 != '0);
   assign fwd2_hit        = out_valid_q & out_rd_we & (out_rd == fwd_rs2) & (fwd_rs2 != '0);
   assign fwd_data        = out_result;
   assign fwd_load_hazard = (fwd1_hit | fwd2_hit) & out_mem_rd;
`else
   logic unused_fwd;
   assign unused_fwd      = ^{fwd_rs1, fwd_rs2};
   assign fwd1_hit        = 1'b0;
   assign fwd2_hit        = 1'b0;
   assign fwd_data        = '0;
   assign fwd_load_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus a randomized
// run against a queue-based reference model of the two-entry stage.
module tb_ex_mem_stage;

   localparam int DW = 32;
   localparam int RW = 5;

   typedef struct {
      logic [DW-1:0] res;
      logic [DW-1:0] sd;
      logic [RW-1:0] rd;
      logic          we;
      logic          mr;
      logic          mw;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready;
   logic [DW-1:0] in_result, in_store_data;
   logic [RW-1:0] in_rd;
   logic          in_rd_we, in_mem_rd, in_mem_wr;
   logic          out_valid, out_ready;
   logic [DW-1:0] out_result, out_store_data;
   logic [RW-1:0] out_rd;
   logic          out_rd_we, out_mem_rd, out_mem_wr;
   logic [RW-1:0] fwd_rs1, fwd_rs2;
   logic          fwd1_hit, fwd2_hit, fwd_load_hazard;
   logic [DW-1:0] fwd_data;

   int   total = 0;
   int   bad   = 0;
   logic fwd_en;
   ent_t q[$];

   always #5 clk = ~clk;

   ex_mem_stage #(.DATA_W(DW), .RD_W(RW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_store_data(in_store_data),
      .in_rd(in_rd), .in_rd_we(in_rd_we), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_store_data(out_store_data),
      .out_rd(out_rd), .out_rd_we(out_rd_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
      .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
      .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
      .fwd_data(fwd_data), .fwd_load_hazard(fwd_load_hazard)
   );

   task automatic idle_inputs();
      flush = 0; in_valid = 0; in_result = '0; in_store_data = '0;
      in_rd = '0; in_rd_we = 0; in_mem_rd = 0; in_mem_wr = 0;
      out_ready = 0; fwd_rs1 = '0; fwd_rs2 = '0;
   endtask

   // Offer one entry for exactly one clock edge.
   task automatic push_one(input logic [DW-1:0] r, input logic [RW-1:0] rd,
                           input logic we, input logic mr);
      @(negedge clk);
      in_valid = 1; in_result = r; in_store_data = ~r; in_rd = rd;
      in_rd_we = we; in_mem_rd = mr; in_mem_wr = 0;
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic do_flush();
      @(negedge clk); flush = 1;
      @(posedge clk); #1; flush = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      #12;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (out_result !== '0) begin bad++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
      total++; if ({fwd1_hit, fwd2_hit, fwd_load_hazard, fwd_data} !== '0) begin bad++; $display("FAIL reset_fwd got=%b%b%b %h exp=0", fwd1_hit, fwd2_hit, fwd_load_hazard, fwd_data); end
      @(negedge clk); rst = 0;
   endtask

   task automatic test_basic();
      out_ready = 1;
      push_one(32'h10, 5'd5, 1'b1, 1'b0);
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
      total++; if (out_result !== 32'h10) begin bad++; $display("FAIL basic_result got=%h exp=00000010", out_result); end
      total++; if (out_rd !== 5'd5) begin bad++; $display("FAIL basic_rd got=%0d exp=5", out_rd); end
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_stream();
      int pops = 0;
      out_ready = 1;
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         if (i > 0) begin
            total++;
            if (out_valid !== 1'b1 || out_result !== 32'h100 + i - 1) begin
               bad++; $display("FAIL stream_%0d got=%b/%h exp=1/%h", i, out_valid, out_result, 32'h100 + i - 1);
            end else pops++;
         end
         in_valid = (i < 8); in_result = 32'h100 + i; in_rd = 5'd1; in_rd_we = 1;
         @(posedge clk); #1;
      end
      in_valid = 0;
      total++; if (pops !== 8) begin bad++; $display("FAIL stream_pops got=%0d exp=8", pops); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 0;
      push_one(32'h1, 5'd2, 1'b1, 1'b0);
      push_one(32'h2, 5'd3, 1'b1, 1'b0);
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
      total++; if (out_result !== 32'h1) begin bad++; $display("FAIL bp_head_a got=%h exp=1", out_result); end
      out_ready = 1;
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_result !== 32'h2) begin bad++; $display("FAIL bp_head_b got=%b/%h exp=1/2", out_valid, out_result); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 0;
      push_one(32'hA, 5'd2, 1'b1, 1'b0);
      push_one(32'hB, 5'd3, 1'b1, 1'b0);
      @(negedge clk);
      flush = 1; in_valid = 1; in_result = 32'hBAD;
      @(posedge clk); #1;
      flush = 0; in_valid = 0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
      out_ready = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_ghost got=%b exp=0", out_valid); end
   endtask

   task automatic test_forward();
      logic [DW-1:0] exp_data;
      exp_data = fwd_en ? 32'hDEADBEEF : '0;
      out_ready = 0;
      push_one(32'hDEADBEEF, 5'd7, 1'b1, 1'b0);
      @(negedge clk); fwd_rs1 = 5'd7; fwd_rs2 = 5'd0; #1;
      total++; if (fwd1_hit !== fwd_en) begin bad++; $display("FAIL fwd1_hit got=%b exp=%b", fwd1_hit, fwd_en); end
      total++; if (fwd2_hit !== 1'b0) begin bad++; $display("FAIL fwd2_rs0 got=%b exp=0", fwd2_hit); end
      total++; if (fwd_data !== exp_data) begin bad++; $display("FAIL fwd_data got=%h exp=%h", fwd_data, exp_data); end
      total++; if (fwd_load_hazard !== 1'b0) begin bad++; $display("FAIL fwd_nohaz got=%b exp=0", fwd_load_hazard); end
      do_flush();
      push_one(32'hDEADBEEF, 5'd7, 1'b1, 1'b1);
      @(negedge clk); fwd_rs1 = 5'd0; fwd_rs2 = 5'd7; #1;
      total++; if (fwd2_hit !== fwd_en) begin bad++; $display("FAIL fwd2_hit got=%b exp=%b", fwd2_hit, fwd_en); end
      total++; if (fwd_load_hazard !== fwd_en) begin bad++; $display("FAIL fwd_haz got=%b exp=%b", fwd_load_hazard, fwd_en); end
      do_flush();
      push_one(32'h1234, 5'd0, 1'b1, 1'b0);
      @(negedge clk); fwd_rs1 = 5'd0; fwd_rs2 = 5'd0; #1;
      total++; if ({fwd1_hit, fwd2_hit} !== 2'b00) begin bad++; $display("FAIL fwd_rd0 got=%b%b exp=00", fwd1_hit, fwd2_hit); end
      do_flush();
   endtask

   task automatic test_async_reset();
      out_ready = 0;
      push_one(32'h55, 5'd4, 1'b1, 1'b0);
      push_one(32'h66, 5'd6, 1'b1, 1'b0);
      @(posedge clk); #3;
      rst = 1; #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
      total++; if (out_result !== '0) begin bad++; $display("FAIL arst_result got=%h exp=0", out_result); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", in_ready); end
      in_valid = 1; in_result = 32'h77; out_ready = 1;
      @(posedge clk); @(negedge clk);
      rst = 0; in_valid = 0;
      @(posedge clk); @(negedge clk);
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL arst_release got=%b/%b exp=0/1", out_valid, in_ready); end
   endtask

   task automatic test_random();
      ent_t e, h;
      logic acc, pp, fl, h1, h2;
      idle_inputs();
      rst = 1; #2; rst = 0;
      q.delete();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         e.res = $urandom; e.sd = $urandom; e.rd = 5'($urandom_range(0, 3));
         e.we = 1'($urandom); e.mr = 1'($urandom); e.mw = 1'($urandom);
         in_valid = 1'($urandom_range(0, 3) != 0);
         in_result = e.res; in_store_data = e.sd; in_rd = e.rd;
         in_rd_we = e.we; in_mem_rd = e.mr; in_mem_wr = e.mw;
         out_ready = 1'($urandom_range(0, 4) < 3);
         fl = ($urandom_range(0, 15) == 0);
         flush = fl;
         fwd_rs1 = 5'($urandom_range(0, 3)); fwd_rs2 = 5'($urandom_range(0, 3));
         #1;
         total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, out_valid, q.size() > 0); end
         total++; if (in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, in_ready, q.size() < 2); end
         h1 = 0; h2 = 0;
         if (q.size() > 0) begin
            h = q[0];
            total++;
            if ({out_result, out_store_data, out_rd, out_rd_we, out_mem_rd, out_mem_wr} !==
                {h.res, h.sd, h.rd, h.we, h.mr, h.mw}) begin
               bad++; $display("FAIL rnd_payload n=%0d got=%h/%h/%0d exp=%h/%h/%0d", n, out_result, out_store_data, out_rd, h.res, h.sd, h.rd);
            end
            h1 = fwd_en && h.we && h.rd == fwd_rs1 && fwd_rs1 != 0;
            h2 = fwd_en && h.we && h.rd == fwd_rs2 && fwd_rs2 != 0;
            total++; if (fwd_load_hazard !== ((h1 | h2) & h.mr)) begin bad++; $display("FAIL rnd_haz n=%0d got=%b exp=%b", n, fwd_load_hazard, (h1 | h2) & h.mr); end
         end
         total++; if ({fwd1_hit, fwd2_hit} !== {h1, h2}) begin bad++; $display("FAIL rnd_hit n=%0d got=%b%b exp=%b%b", n, fwd1_hit, fwd2_hit, h1, h2); end
         acc = in_valid && (q.size() < 2);
         pp  = out_ready && (q.size() > 0);
         @(posedge clk);
         if (pp) void'(q.pop_front());
         if (fl) q.delete();
         else if (acc) q.push_back(e);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
`ifdef EX_MEM_FORWARD_EN
      fwd_en = 1'b1;
`else
      fwd_en = 1'b0;
`endif
      test_reset();
      test_basic();
      test_stream();
      test_back_to_back();
      test_flush();
      test_forward();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
